// File: rtl/lc3_int_arbiter.sv
// lc3_int_arbiter: registered interrupt/exception arbiter with req/ack handshake and nesting depth.
// Optional INT_RR_TIE_EN: round-robin tie-break among equal-priority devices.
module lc3_int_arbiter #(
   parameter int         N_DEV    = 3,
   parameter logic [7:0] VEC_BASE = 8'h02,
   parameter int         MAX_NEST = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_DEV-1:0]   dev_ready,
   input  logic [N_DEV-1:0]   dev_ie,
   input  logic [3*N_DEV-1:0] dev_pri,
   input  logic [2:0]         cur_pri,
   input  logic               exc_priv,
   input  logic               exc_opc,
   input  logic               int_ack,
   input  logic               rti_done,
   output logic               int_req,
   output logic [7:0]         int_vector,
   output logic [2:0]         int_pri,
   output logic [N_DEV-1:0]   svc_strobe,
   output logic [2:0]         nest_depth,
   output logic               err
);
   localparam int IW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
   typedef enum logic {IDLE, PEND} state_t;
   state_t           state_q;
   logic [IW-1:0]    src_idx_q, win_idx;
   logic             src_exc_q, win_found, exc, ack, withdraw, err_q, err_d;
   logic [2:0]       win_pri, depth_q, depth_d, pri_q;
   logic [7:0]       vec_q;
   logic [N_DEV-1:0] elig, svc_q;
   assign exc = exc_priv | exc_opc;
   assign ack = (state_q == PEND) && int_ack;
   for (genvar i = 0; i < N_DEV; i++) begin : g_elig
      assign elig[i] = dev_ready[i] & dev_ie[i] & (dev_pri[3*i +: 3] > cur_pri) & (depth_q < 3'(MAX_NEST));
   end
   // A pending device request is dropped once its source stops qualifying; exceptions stay.
   assign withdraw = (state_q == PEND) && !int_ack && !src_exc_q && !elig[src_idx_q];
`ifdef INT_RR_TIE_EN
   logic [IW-1:0] rr_q;
   always_ff @(posedge clk) begin
      if (rst) rr_q <= '0;
      else if (ack && !src_exc_q) rr_q <= (int'(src_idx_q) == N_DEV - 1) ? '0 : src_idx_q + 1'b1;
   end
`endif
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_pri   = '0;
      for (int k = 0; k < N_DEV; k++) begin
         int j;
`ifdef INT_RR_TIE_EN
         j = (int'(rr_q) + k) % N_DEV;
`else
         j = k;
`endif
         if (elig[j] && (!win_found || dev_pri[3*j +: 3] > win_pri)) begin
            win_found = 1'b1;
            win_idx   = IW'(j);
            win_pri   = dev_pri[3*j +: 3];
         end
      end
   end
   always_comb begin
      depth_d = depth_q;
      err_d   = err_q;
      if (ack && !rti_done) begin
         if (depth_q == 3'(MAX_NEST)) err_d = 1'b1;
         else depth_d = depth_q + 3'd1;
      end else if (rti_done && !ack) begin
         if (depth_q == 3'd0) err_d = 1'b1;
         else depth_d = depth_q - 3'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         vec_q     <= 8'h00;
         pri_q     <= 3'b000;
         svc_q     <= '0;
         depth_q   <= 3'd0;
         err_q     <= 1'b0;
         src_exc_q <= 1'b0;
         src_idx_q <= '0;
      end else begin
         depth_q <= depth_d;
         err_q   <= err_d;
         svc_q   <= (ack && !src_exc_q) ? N_DEV'(1) << src_idx_q : '0;
         if (state_q == IDLE) begin
            if (exc || win_found) begin
               state_q   <= PEND;
               src_exc_q <= exc;
               src_idx_q <= win_idx;
               vec_q     <= exc_priv ? 8'h00 : exc_opc ? 8'h01 : VEC_BASE + 8'(win_idx);
               pri_q     <= exc ? cur_pri : win_pri;
            end
         end else if (ack || withdraw) begin
            state_q <= IDLE;
         end
      end
   end
   assign int_req    = (state_q == PEND);
   assign int_vector = vec_q;
   assign int_pri    = pri_q;
   assign svc_strobe = svc_q;
   assign nest_depth = depth_q;
   assign err        = err_q;
endmodule

// File: tb/tb_lc3_int_arbiter.sv
// tb_lc3_int_arbiter: directed stimulus, per-cycle check against a behavioural arbiter model.
module tb_lc3_int_arbiter;
   logic       clk = 1'b0, rst = 1'b1;
   logic [2:0] dev_ready = '0, dev_ie = '0, cur_pri = '0;
   logic [8:0] dev_pri = '0;
   logic       exc_priv = 1'b0, exc_opc = 1'b0, int_ack = 1'b0, rti_done = 1'b0;
   logic       int_req, err;
   logic [7:0] int_vector;
   logic [2:0] int_pri, svc_strobe, nest_depth;
   int checks = 0, failures = 0;
   bit mon_en = 1'b0;
   bit m_pend, m_exc, m_err;
   int m_src, m_depth, m_rr;
   logic [7:0] m_vec;
   logic [2:0] m_pri, m_svc;
   int acc_q[$];
   lc3_int_arbiter dut (
      .clk(clk), .rst(rst), .dev_ready(dev_ready), .dev_ie(dev_ie), .dev_pri(dev_pri),
      .cur_pri(cur_pri), .exc_priv(exc_priv), .exc_opc(exc_opc), .int_ack(int_ack),
      .rti_done(rti_done), .int_req(int_req), .int_vector(int_vector), .int_pri(int_pri),
      .svc_strobe(svc_strobe), .nest_depth(nest_depth), .err(err)
   );
   always #5 clk = ~clk;
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic bit m_elig(int i);
      return dev_ready[i] && dev_ie[i] && int'(dev_pri[3*i +: 3]) > int'(cur_pri) && m_depth < 7;
   endfunction
   // Highest priority wins; equal priorities resolve in search order from the start index.
   function automatic int m_pick();
      int bp = -1, st = 0;
`ifdef INT_RR_TIE_EN
      st = m_rr;
`endif
      for (int i = 0; i < 3; i++) if (m_elig(i) && int'(dev_pri[3*i +: 3]) > bp) bp = int'(dev_pri[3*i +: 3]);
      for (int k = 0; k < 3; k++) begin
         int i = (st + k) % 3;
         if (bp >= 0 && m_elig(i) && int'(dev_pri[3*i +: 3]) == bp) return i;
      end
      return -1;
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         m_pend = 0; m_exc = 0; m_err = 0; m_src = 0; m_depth = 0; m_rr = 0;
         m_vec = 8'h00; m_pri = 3'd0; m_svc = 3'd0;
      end else begin
         int nd, w;
         nd = m_depth + ((m_pend && int_ack) ? 1 : 0) - (rti_done ? 1 : 0);
         if (nd < 0) begin nd = 0; m_err = 1; end
         if (nd > 7) begin nd = 7; m_err = 1; end
         m_svc = 3'd0;
         w = m_pick();
         if (!m_pend) begin
            if (exc_priv || exc_opc) begin
               m_pend = 1; m_exc = 1; m_vec = exc_priv ? 8'h00 : 8'h01; m_pri = cur_pri;
            end else if (w >= 0) begin
               m_pend = 1; m_exc = 0; m_src = w; m_vec = 8'(2 + w); m_pri = dev_pri[3*w +: 3];
            end
         end else if (int_ack) begin
            m_pend = 0;
            if (!m_exc) begin m_svc[m_src] = 1'b1; m_rr = (m_src + 1) % 3; end
         end else if (!m_exc && !m_elig(m_src)) m_pend = 0;
         m_depth = nd;
      end
   end
   always @(negedge clk) begin
      if (mon_en) begin
         chk("int_req", 32'(int_req), 32'(m_pend));
         if (m_pend) begin
            chk("int_vector", 32'(int_vector), 32'(m_vec));
            chk("int_pri", 32'(int_pri), 32'(m_pri));
         end
         chk("svc_strobe", 32'(svc_strobe), 32'(m_svc));
         chk("nest_depth", 32'(nest_depth), 32'(m_depth));
         chk("err", 32'(err), 32'(m_err));
         for (int i = 0; i < 3; i++) if (svc_strobe[i]) acc_q.push_back(i);
      end
   end
   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic set_dev(int i, bit r, bit e, logic [2:0] p);
      dev_ready[i] = r; dev_ie[i] = e; dev_pri[3*i +: 3] = p;
   endtask
   task automatic clear_in();
      dev_ready = '0; dev_ie = '0; dev_pri = '0; cur_pri = '0;
      exc_priv = 0; exc_opc = 0; int_ack = 0; rti_done = 0;
   endtask
   task automatic do_reset();
      clear_in(); rst = 1; tick(1); rst = 0;
   endtask
   task automatic pulse_ack(bit with_rti);
      int_ack = 1; rti_done = with_rti; tick(1); int_ack = 0; rti_done = 0;
   endtask
   task automatic wait_req(string nm);
      int n = 0;
      while (!int_req && n < 20) begin tick(1); n++; end
      chk(nm, 32'(int_req), 32'd1);
   endtask
   task automatic chk_out(string nm, bit req, logic [7:0] vec, logic [2:0] pri);
      chk({nm, "_req"}, 32'(int_req), 32'(req));
      if (req) begin
         chk({nm, "_vec"}, 32'(int_vector), 32'(vec));
         chk({nm, "_pri"}, 32'(int_pri), 32'(pri));
      end
   endtask
   initial begin
      int exp_acc[4];
      tick(1);
      mon_en = 1;
      chk("rst_req", 32'(int_req), 0); chk("rst_vec", 32'(int_vector), 0);
      chk("rst_depth", 32'(nest_depth), 0); chk("rst_err", 32'(err), 0);
      rst = 0;
      // single device handshake
      set_dev(0, 1, 1, 3'd4); tick(1);
      chk_out("t1", 1, 8'h02, 3'd4);
      pulse_ack(0);
      chk("t1_svc", 32'(svc_strobe), 32'b001); chk("t1_depth", 32'(nest_depth), 1);
      dev_ready[0] = 0; tick(1);
      chk("t1_svc_off", 32'(svc_strobe), 0);
      rti_done = 1; tick(1); rti_done = 0;
      chk("t1_rti_depth", 32'(nest_depth), 0);
      // priority and masking
      do_reset();
      set_dev(1, 1, 1, 3'd5); set_dev(2, 1, 1, 3'd6); cur_pri = 3'd5; tick(1);
      chk_out("t2", 1, 8'h04, 3'd6);
      cur_pri = 3'd6; tick(2);
      chk("t2_masked", 32'(int_req), 0);
      // exception precedence
      do_reset();
      set_dev(0, 1, 1, 3'd4); cur_pri = 3'd2; exc_opc = 1; exc_priv = 1; tick(1);
      chk_out("t3_priv", 1, 8'h00, 3'd2);
      exc_priv = 0; set_dev(0, 0, 0, 3'd0); pulse_ack(0);
      chk("t3_no_svc", 32'(svc_strobe), 0);
      tick(1);
      chk_out("t3_opc", 1, 8'h01, 3'd2);
      // withdraw
      do_reset();
      set_dev(0, 1, 1, 3'd4); tick(1);
      chk("t4_pend", 32'(int_req), 1);
      dev_ready[0] = 0; tick(1);
      chk("t4_withdraw", 32'(int_req), 0); chk("t4_nosvc", 32'(svc_strobe), 0);
      // stability against a later higher source
      do_reset();
      set_dev(0, 1, 1, 3'd3); tick(1);
      set_dev(2, 1, 1, 3'd6); tick(2);
      chk_out("t4_hold", 1, 8'h02, 3'd3);
      pulse_ack(0);
      chk("t4_svc", 32'(svc_strobe), 32'b001);
      tick(1);
      chk_out("t4_next", 1, 8'h04, 3'd6);
      // RTI underflow
      do_reset();
      rti_done = 1; tick(1); rti_done = 0;
      chk("t5_uf_err", 32'(err), 1); chk("t5_uf_depth", 32'(nest_depth), 0);
      // nesting to the limit, then exception overflow
      do_reset();
      set_dev(0, 1, 1, 3'd7);
      for (int i = 0; i < 7; i++) begin wait_req("t5_nest_req"); pulse_ack(0); end
      chk("t5_depth7", 32'(nest_depth), 7); chk("t5_err0", 32'(err), 0);
      tick(3);
      chk("t5_suppress", 32'(int_req), 0);
      exc_opc = 1; wait_req("t5_exc_req");
      chk_out("t5_exc", 1, 8'h01, 3'd0);
      pulse_ack(0);
      chk("t5_sat", 32'(nest_depth), 7); chk("t5_ovf_err", 32'(err), 1);
      wait_req("t5_exc_again");
      pulse_ack(1);
      chk("t5_ack_rti", 32'(nest_depth), 7);
      wait_req("t5_pend_rst");
      rst = 1; tick(1); rst = 0; clear_in();
      chk("t5_rst_req", 32'(int_req), 0); chk("t5_rst_vec", 32'(int_vector), 0);
      chk("t5_rst_pri", 32'(int_pri), 0); chk("t5_rst_svc", 32'(svc_strobe), 0);
      chk("t5_rst_depth", 32'(nest_depth), 0); chk("t5_rst_err", 32'(err), 0);
      // tie-break order
      do_reset();
      set_dev(0, 1, 1, 3'd4); set_dev(1, 1, 1, 3'd4); set_dev(2, 1, 1, 3'd4);
      acc_q.delete();
      for (int r = 0; r < 4; r++) begin wait_req("t6_req"); pulse_ack(1); end
      tick(1);
`ifdef INT_RR_TIE_EN
      exp_acc = '{0, 1, 2, 0};
`else
      exp_acc = '{0, 0, 0, 0};
`endif
      chk("t6_count", 32'(acc_q.size()), 4);
      for (int r = 0; r < 4 && r < acc_q.size(); r++) chk("t6_order", 32'(acc_q[r]), 32'(exp_acc[r]));
      clear_in(); tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
